// File: rtl/fp32_defines.sv
// Shared FP32 field widths, alignment width and operand helpers for the block aligner.
// FP32_ALIGN_DENORM_EN selects whether denormals align (exp_eff=1) or flush to signed zero.
package fp32_defines;

    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int MANT_W     = 24;
    localparam int GUARD_BITS = 3;
    localparam int ALIGN_W    = MANT_W + GUARD_BITS;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = '1;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Specials return their raw exponent; callers exclude them from the block maximum.
    function automatic logic [EXP_W-1:0] eff_exp(input fp32_t op);
        logic [EXP_W-1:0] e;
        e = op.exp;
`ifdef FP32_ALIGN_DENORM_EN
        if (op.exp == '0 && op.frac != '0) begin
            e = EXP_W'(1);
        end
`endif
        return e;
    endfunction

    function automatic logic [ALIGN_W-1:0] mant_ext(input fp32_t op);
        logic [ALIGN_W-1:0] m;
        m = '0;
        if (op.exp == EXP_SPECIAL) begin
            m = '0;
        end else if (op.exp != '0) begin
            m = {1'b1, op.frac, {GUARD_BITS{1'b0}}};
        end else begin
`ifdef FP32_ALIGN_DENORM_EN
            m = {1'b0, op.frac, {GUARD_BITS{1'b0}}};
`else
            m = '0;
`endif
        end
        return m;
    endfunction

endpackage

// File: rtl/fp32_align_shifter.sv
// Right shift of an extended mantissa with every shifted-out bit folded into bit 0 (sticky).
module fp32_align_shifter
    import fp32_defines::*;
(
    input  logic [ALIGN_W-1:0] mant_in,
    input  logic [EXP_W-1:0]   shift,
    output logic [ALIGN_W-1:0] mant_out
);

    logic [ALIGN_W-1:0] lost_mask;
    logic [ALIGN_W-1:0] shifted;
    logic               sticky;

    genvar gi;
    generate
        for (gi = 0; gi < ALIGN_W; gi++) begin : g_mask
            assign lost_mask[gi] = (EXP_W'(gi) < shift);
        end
    endgenerate

    always_comb begin
        shifted  = mant_in >> shift;
        sticky   = |(mant_in & lost_mask);
        mant_out = {shifted[ALIGN_W-1:1], shifted[0] | sticky};
        if (shift >= EXP_W'(ALIGN_W)) begin
            mant_out = {{(ALIGN_W-1){1'b0}}, |mant_in};
        end
    end

endmodule

// File: rtl/fp32_unpack_aligner.sv
// Collects NUM_OPS FP32 operands, then streams them aligned to the block maximum exponent.
// Denormal handling is selected by FP32_ALIGN_DENORM_EN (see fp32_defines).
module fp32_unpack_aligner
    import fp32_defines::*;
#(
    parameter int NUM_OPS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic [ALIGN_W-1:0] out_mant,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_last,
    output logic               out_special
);

    localparam int              CNT_W    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OPS - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [EXP_W-1:0]   max_exp_reg;
    logic               special_reg;
    logic               ready_reg;
    logic [31:0]        buf_mem [NUM_OPS];

    logic               out_valid_reg, out_last_reg, out_sign_reg, out_special_reg;
    logic [ALIGN_W-1:0] out_mant_reg;
    logic [EXP_W-1:0]   out_exp_reg;

    logic               fill_fire, drain_load, drain_done;
    logic [CNT_W-1:0]   cnt_inc;
    fp32_t              in_op, rd_op;
    logic [EXP_W-1:0]   in_eff, rd_eff, rd_shift;
    logic [ALIGN_W-1:0] aligned;

    assign in_op    = in_data;
    assign in_eff   = eff_exp(in_op);
    assign rd_op    = buf_mem[cnt_reg];
    assign rd_eff   = eff_exp(rd_op);
    assign rd_shift = max_exp_reg - rd_eff;
    assign cnt_inc  = (cnt_reg == LAST_IDX) ? '0 : cnt_reg + CNT_W'(1);

    fp32_align_shifter u_shifter (
        .mant_in  (mant_ext(rd_op)),
        .shift    (rd_shift),
        .mant_out (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FILL:  if (fill_fire && cnt_reg == LAST_IDX) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_next = ST_FILL;
            default:  state_next = ST_FILL;
        endcase
    end

    // ready_reg keeps in_ready low during reset and until the first edge after release.
    always_comb begin
        in_ready   = (state_reg == ST_FILL) && ready_reg;
        fill_fire  = in_valid && in_ready;
        drain_load = (state_reg == ST_DRAIN) &&
                     (!out_valid_reg || (out_ready && !out_last_reg));
        drain_done = (state_reg == ST_DRAIN) && out_valid_reg && out_ready && out_last_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            max_exp_reg <= '0;
            special_reg <= 1'b0;
            ready_reg   <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
            if (fill_fire) begin
                cnt_reg <= cnt_inc;
                if (in_op.exp == EXP_SPECIAL) begin
                    special_reg <= 1'b1;
                end else if (in_eff > max_exp_reg) begin
                    max_exp_reg <= in_eff;
                end
            end else if (drain_load) begin
                cnt_reg <= cnt_inc;
            end
            if (drain_done) begin
                max_exp_reg <= '0;
                special_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_fire) begin
            buf_mem[cnt_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            out_sign_reg    <= 1'b0;
            out_special_reg <= 1'b0;
            out_mant_reg    <= '0;
            out_exp_reg     <= '0;
        end else if (drain_load) begin
            out_valid_reg   <= 1'b1;
            out_last_reg    <= (cnt_reg == LAST_IDX);
            out_sign_reg    <= rd_op.sign;
            out_special_reg <= special_reg;
            out_mant_reg    <= aligned;
            out_exp_reg     <= max_exp_reg;
        end else if (drain_done) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_last    = out_last_reg;
    assign out_sign    = out_sign_reg;
    assign out_special = out_special_reg;
    assign out_mant    = out_mant_reg;
    assign out_exp     = out_exp_reg;

endmodule

// File: tb/tb_fp32_unpack_aligner.sv
// Randomized self-checking bench for fp32_unpack_aligner against an arithmetic reference model.
module tb_fp32_unpack_aligner;

    localparam int N = 4;
`ifdef FP32_ALIGN_DENORM_EN
    localparam bit DENORM_EN = 1'b1;
`else
    localparam bit DENORM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_sign, out_last, out_special;
    logic [26:0] out_mant;
    logic [7:0]  out_exp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp32_unpack_aligner #(.NUM_OPS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_mant    (out_mant),
        .out_exp     (out_exp),
        .out_last    (out_last),
        .out_special (out_special)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: effective exponent, -1 marks Inf/NaN.
    function automatic int m_eff(input logic [31:0] d);
        int e;
        e = int'(d[30:23]);
        if (e == 255) return -1;
        if (e != 0) return e;
        if (DENORM_EN && d[22:0] != 0) return 1;
        return 0;
    endfunction

    // Reference: value scaled by 2^(GUARD_BITS+23), divided by 2^shift, inexact -> LSB set.
    function automatic longint m_mant(input logic [31:0] d, input int mx);
        longint v;
        int     s;
        int     e;
        e = int'(d[30:23]);
        if (e == 255) return 0;
        if (e != 0) v = (longint'(1) << 26) + longint'(d[22:0]) * 8;
        else if (DENORM_EN) v = longint'(d[22:0]) * 8;
        else v = 0;
        s = mx - m_eff(d);
        if (s >= 27) return (v != 0) ? 1 : 0;
        return (v >> s) | (((v % (longint'(1) << s)) != 0) ? 1 : 0);
    endfunction

    task automatic send_op(input logic [31:0] d);
        int n;
        n = 0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic model_block(input logic [31:0] ops[N], output int mx, output bit sp);
        mx = 0;
        sp = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_eff(ops[i]) < 0) sp = 1'b1;
            else if (m_eff(ops[i]) > mx) mx = m_eff(ops[i]);
        end
    endtask

    task automatic check_beat(input string name, input int k, input logic [31:0] op,
                              input int mx, input bit sp);
        check({name, " valid"},   32'(out_valid), 32'd1);
        check({name, " sign"},    32'(out_sign), 32'(op[31]));
        check({name, " mant"},    32'(out_mant), 32'(m_mant(op, mx)));
        check({name, " exp"},     32'(out_exp), 32'(mx));
        check({name, " last"},    32'(out_last), 32'(k == N - 1));
        check({name, " special"}, 32'(out_special), 32'(sp));
        check({name, " in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic run_block(input string name, input logic [31:0] ops[N]);
        int mx;
        bit sp;
        int n;
        model_block(ops, mx, sp);
        for (int i = 0; i < N; i++) send_op(ops[i]);
        check({name, " lat0"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({name, " lat1"}, 32'(out_valid), 32'd1);
        for (int k = 0; k < N; k++) begin
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'b0;
                @(negedge clk);
            end
            check_beat($sformatf("%s b%0d", name, k), k, ops[k], mx, sp);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check({name, " done_valid"}, 32'(out_valid), 32'd0);
        check({name, " done_ready"}, 32'(in_ready), 32'd1);
        $display("block %s: ops %h %h %h %h max_exp %0d special %0d",
                 name, ops[0], ops[1], ops[2], ops[3], mx, sp);
    endtask

    task automatic reset_pulse(input string name);
        rst_n = 1'b0;
        #1;
        check({name, " rst valid"},   32'(out_valid), 32'd0);
        check({name, " rst ready"},   32'(in_ready), 32'd0);
        check({name, " rst mant"},    32'(out_mant), 32'd0);
        check({name, " rst exp"},     32'(out_exp), 32'd0);
        check({name, " rst last"},    32'(out_last), 32'd0);
        check({name, " rst special"}, 32'(out_special), 32'd0);
        check({name, " rst sign"},    32'(out_sign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check({name, " rel ready0"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        check({name, " rel ready1"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_op(input int base);
        int          c;
        int          ei;
        logic [22:0] f;
        logic        s;
        c = int'($urandom_range(0, 15));
        f = 23'($urandom);
        s = 1'($urandom);
        if (c == 0) return {s, 31'b0};
        if (c == 1) return {s, 8'h00, f | 23'd1};
        if (c == 2) return {s, 8'hFF, ($urandom_range(0, 1) != 0) ? 23'd0 : (f | 23'd1)};
        ei = base + int'($urandom_range(0, 35));
        if (ei > 254) ei = 254;
        return {s, 8'(ei), f};
    endfunction

    initial begin
        logic [31:0] blk [N];
        int mx;
        bit sp;

        @(negedge clk);
        reset_pulse("init");

        blk = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000};
        run_block("basic", blk);
        blk = '{32'h3F800000, 32'h4E800000, 32'h00000000, 32'h80000000};
        run_block("sticky", blk);
        blk = '{32'h3F800000, 32'h7F800000, 32'h40400000, 32'hC0000000};
        run_block("inf", blk);
        blk = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
        run_block("denorm", blk);

        // Partial block followed by reset must leave no trace.
        send_op(32'h47000000);
        send_op(32'h3F800000);
        reset_pulse("midfill");
        blk = '{32'h40000000, 32'h3E800000, 32'h80000000, 32'h41000000};
        run_block("after_fill_rst", blk);

        // Backpressure on beat 1, then reset while draining.
        blk = '{32'h40A00000, 32'hC1200000, 32'h3DCCCCCD, 32'h00000000};
        model_block(blk, mx, sp);
        for (int i = 0; i < N; i++) send_op(blk[i]);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_beat($sformatf("hold c%0d", c), 1, blk[1], mx, sp);
            @(negedge clk);
        end
        reset_pulse("middrain");
        blk = '{32'hC2C80000, 32'h3C23D70A, 32'h00400000, 32'h42280000};
        run_block("after_drain_rst", blk);

        for (int b = 0; b < 40; b++) begin
            int base;
            base = int'($urandom_range(1, 220));
            for (int i = 0; i < N; i++) blk[i] = rand_op(base);
            run_block($sformatf("rnd%0d", b), blk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp32_unpack_aligner.md
FP32_UNPACK_ALIGNER -- requirements
Module: fp32_unpack_aligner

Interface
REQ-001 SHALL have parameter NUM_OPS, default 8: number of FP32 operands per block; legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-006 SHALL have port in_data, input, 32 bits: FP32 operand.
REQ-007 SHALL have port out_valid, output, 1 bit: output beat is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-009 SHALL have port out_sign, output, 1 bit: operand sign.
REQ-010 SHALL have port out_mant, output, 24+GUARD_BITS bits: aligned magnitude, with sticky ORed into bit 0.
REQ-011 SHALL have port out_exp, output, 8 bits: block maximum effective exponent.
REQ-012 SHALL have port out_last, output, 1 bit: final beat of a block.
REQ-013 SHALL have port out_special, output, 1 bit: the block contains Inf or NaN.

Function
REQ-014 SHALL run an FSM with states FILL and DRAIN; reset state is FILL.
REQ-015 In FILL, in_ready SHALL be 1; each in_valid&&in_ready transfer stores the operand into buffer slot cnt, and cnt increments.
REQ-016 During FILL, the block SHALL track max_exp, the maximum effective exponent over finite operands; max_exp resets to 0 at block start.
REQ-017 Effective exponent SHALL be: the raw exponent for normals; 1 for denormals (macro on) or 0 for denormals (macro off); 0 for zero.
REQ-018 Operands with exponent 255 SHALL set the block special flag, are excluded from max_exp, and emit out_mant 0.
REQ-019 On the transfer of operand NUM_OPS-1, the FSM SHALL move to DRAIN with cnt=0; out_valid SHALL rise on the next cycle (1-cycle latency); in_ready SHALL be 0 throughout DRAIN.
REQ-020 In DRAIN, beat k SHALL present operand k: mant_ext = {hidden, frac, GUARD_BITS zeros}, shifted right by max_exp - exp_eff.
REQ-021 Shifted-out bits SHALL be ORed into out_mant[0]; if the shift is at least 24+GUARD_BITS, out_mant SHALL be {0..0, |mant_ext}.
REQ-022 Hidden bit SHALL be 1 for normals and 0 for denormals and zero.
REQ-023 Beat k SHALL advance only on out_valid&&out_ready; while out_ready=0, all out_* SHALL hold stable.
REQ-024 out_last SHALL be 1 on beat NUM_OPS-1; its acceptance SHALL return the FSM to FILL and clear the special flag and max_exp.
REQ-025 out_exp and out_special SHALL be constant for all beats of a block.
REQ-026 Blocks SHALL NOT overlap: there is no input acceptance during DRAIN and no output during FILL.
REQ-027 Signed zero SHALL pass out_sign unchanged with out_mant 0.

Reset
REQ-028 When rst_n=0, the block SHALL immediately force state FILL, cnt=0, max_exp=0, special=0, and out_valid, out_last, out_special, out_sign, out_mant and out_exp to 0.
REQ-029 in_ready SHALL be 0 while rst_n=0 and 1 from the first clk edge after release.
REQ-030 Reset mid-block SHALL discard all buffered operands; no partial block SHALL be emitted.

Configuration
REQ-031 Macro FP32_ALIGN_DENORM_EN defined: denormals SHALL align as exp_eff=1, hidden=0.
REQ-032 Macro FP32_ALIGN_DENORM_EN undefined: denormals SHALL be flushed to signed zero (out_mant 0, exp_eff 0).

Structure
REQ-033 FP32 field widths, GUARD_BITS, and the aligned width 24+GUARD_BITS SHALL come from the shared fp32_defines header; no local redefinition.
REQ-034 Shift-plus-sticky logic SHALL be a combinational sub-module, fp32_align_shifter, instantiated once on the drain path.

Verification
REQ-035 NUM_OPS=4, inputs 3F800000, 40000000, 3F000000, BF800000 -> out_exp 0x80; out_mant 2000000, 4000000, 1000000, 2000000 (hex, GUARD_BITS=3); signs 0,0,0,1; out_last only on beat 3.
REQ-036 Inputs 3F800000, 4E800000, then zeros -> out_exp 0x9D; 1.0 beat out_mant 0000001 (sticky only); zero beats out_mant 0.
REQ-037 Input 7F800000 within the block -> out_special=1 on all 4 beats; that beat's out_mant 0; out_exp from the finite operands.
REQ-038 All operands 00000001 -> macro on: out_exp 1, out_mant 0000008; macro off: out_exp 0, out_mant 0.
REQ-039 Hold out_ready=0 for 5 cycles on beat 1 -> outputs stable and in_ready 0; then assert rst_n=0 mid-DRAIN -> out_valid 0 immediately, and a fresh block afterwards is emitted correctly.
